// File: rtl/simple_mem_slave_if.sv
// simple_mem_slave_if: multiplexed address/data bus between a master and simple_mem_slave.
interface simple_mem_slave_if;
  logic [31:0] bus_addrData_i;
  logic [3:0]  bus_byteEnables_i;
  logic [7:0]  bus_burstSize_i;
  logic        bus_readNWrite_i;
  logic        bus_beginTransaction_i;
  logic        bus_endTransaction_i;
  logic        bus_dataValid_i;
  logic [31:0] bus_addrData_o;
  logic        bus_endTransaction_o;
  logic        bus_dataValid_o;
  logic        bus_busy_o;
  logic        bus_error_o;
  modport slave (
    input  bus_addrData_i, bus_byteEnables_i, bus_burstSize_i, bus_readNWrite_i,
           bus_beginTransaction_i, bus_endTransaction_i, bus_dataValid_i,
    output bus_addrData_o, bus_endTransaction_o, bus_dataValid_o, bus_busy_o, bus_error_o
  );
  modport master (
    output bus_addrData_i, bus_byteEnables_i, bus_burstSize_i, bus_readNWrite_i,
           bus_beginTransaction_i, bus_endTransaction_i, bus_dataValid_i,
    input  bus_addrData_o, bus_endTransaction_o, bus_dataValid_o, bus_busy_o, bus_error_o
  );
endinterface

// File: rtl/simple_mem_slave.sv
// simple_mem_slave: behavioural word-addressed RAM slave with single/burst reads and writes.
// Define SIMPLE_MEM_SLAVE_WAITSTATE_EN for one wait cycle per write beat and a gap between read beats.
module simple_mem_slave #(
  parameter logic [31:0] baseAddr = 32'h0000_0000,
  parameter int          memSize  = 1024*256
) (
  input logic              clk_i,
  input logic              rst_ni,
  simple_mem_slave_if.slave bus
);
  localparam int AW = $clog2(memSize);
  localparam logic [32:0] LIMIT = {1'b0, baseAddr} + (33'(memSize) << 2);
  typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, ERROR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [8:0] rem_q, rem_d;
  logic [31:0] data_q, data_d;
  logic valid_q, valid_d, end_q, end_d, busy_q, busy_d, err_q, err_d, gap_q, gap_d, we;
  logic [31:0] mem [memSize] = '{default: '0};
  logic [29:0] word;
  logic [32:0] last;
  logic sel, oob;
  assign word = bus.bus_addrData_i[31:2] - baseAddr[31:2];
  assign sel  = {1'b0, bus.bus_addrData_i} >= {1'b0, baseAddr} && {1'b0, bus.bus_addrData_i} < LIMIT;
  assign last = 33'(word) + 33'(bus.bus_burstSize_i);
  assign oob  = last >= 33'(memSize);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    data_d  = '0;
    valid_d = 1'b0;
    end_d   = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    gap_d   = gap_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (bus.bus_beginTransaction_i && sel) begin
        idx_d = word[AW-1:0];
        rem_d = {1'b0, bus.bus_burstSize_i} + 9'd1;
        gap_d = 1'b0;
        if (oob) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (bus.bus_readNWrite_i) state_d = READ;
        else begin
          state_d = WRITE;
`ifdef SIMPLE_MEM_SLAVE_WAITSTATE_EN
          busy_d  = 1'b1;
`endif
        end
      end
      READ: if (bus.bus_endTransaction_i) state_d = IDLE;
      else if (gap_q) gap_d = 1'b0;
      else begin
        data_d  = mem[idx_q];
        valid_d = 1'b1;
        idx_d   = idx_q + AW'(1);
        rem_d   = rem_q - 9'd1;
        state_d = rem_q == 9'd1 ? READ_END : READ;
`ifdef SIMPLE_MEM_SLAVE_WAITSTATE_EN
        gap_d   = 1'b1;
`endif
      end
      READ_END: begin
        state_d = IDLE;
        end_d   = !bus.bus_endTransaction_i;
      end
      WRITE: if (bus.bus_endTransaction_i) state_d = IDLE;
      else if (bus.bus_dataValid_i && !busy_q && rem_q != 9'd0) begin
        we    = 1'b1;
        idx_d = idx_q + AW'(1);
        rem_d = rem_q - 9'd1;
`ifdef SIMPLE_MEM_SLAVE_WAITSTATE_EN
        busy_d = 1'b1;
`endif
      end
      ERROR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end
  // Memory survives reset, so it has its own unreset write port.
  always_ff @(posedge clk_i) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (bus.bus_byteEnables_i[i]) mem[idx_q][8*i +: 8] <= bus.bus_addrData_i[8*i +: 8];
  end
  assign bus.bus_addrData_o       = data_q;
  assign bus.bus_dataValid_o      = valid_q;
  assign bus.bus_endTransaction_o = end_q;
  assign bus.bus_busy_o           = busy_q;
  assign bus.bus_error_o          = err_q;
endmodule

// File: tb/tb_simple_mem_slave.sv
// tb_simple_mem_slave: directed scoreboard bench for simple_mem_slave.
module tb_simple_mem_slave;
`ifdef SIMPLE_MEM_SLAVE_WAITSTATE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  simple_mem_slave_if bus();
  simple_mem_slave dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.bus_addrData_i = '0;
    bus.bus_byteEnables_i = '0;
    bus.bus_burstSize_i = '0;
    bus.bus_readNWrite_i = 1'b0;
    bus.bus_beginTransaction_i = 1'b0;
    bus.bus_endTransaction_i = 1'b0;
    bus.bus_dataValid_i = 1'b0;
  endtask

  task automatic begin_tx(input logic [31:0] addr, input logic [7:0] burst, input logic rnw);
    @(posedge clk); #1;
    bus.bus_beginTransaction_i = 1'b1;
    bus.bus_addrData_i = addr;
    bus.bus_burstSize_i = burst;
    bus.bus_readNWrite_i = rnw;
    @(posedge clk); #1;
    bus.bus_beginTransaction_i = 1'b0;
    bus.bus_addrData_i = '0;
  endtask

  task automatic write_words(input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be,
                             input logic [31:0] d0, input int step);
    int k = 0;
    bit acc;
    begin_tx(addr, burst, 1'b0);
    for (int t = 0; t < 600 && k <= int'(burst); t++) begin
      bus.bus_addrData_i = d0 + 32'(k * step);
      bus.bus_byteEnables_i = be;
      bus.bus_dataValid_i = 1'b1;
      @(negedge clk);
      acc = !bus.bus_busy_o;
      @(posedge clk); #1;
      if (acc) k++;
    end
    chk("wr_beats_accepted", k, 32'(burst) + 1);
    bus.bus_dataValid_i = 1'b0;
    bus.bus_addrData_i = '0;
    bus.bus_endTransaction_i = 1'b1;
    @(posedge clk); #1;
    bus.bus_endTransaction_i = 1'b0;
  endtask

  // stop_after > 0: after that many beats, abort (use_reset=0) or pulse reset (use_reset=1)
  task automatic do_read(input logic [31:0] addr, input logic [7:0] burst, input int stop_after, input bit use_reset);
    int beats = 0, first = -1, last = -1, endc = -1, ends = 0, stopc = 0;
    bit stopped = 0;
    logic [31:0] e;
    begin_tx(addr, burst, 1'b1);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (stopped) begin
        chk("stop_valid", bus.bus_dataValid_o, 0);
        chk("stop_end", bus.bus_endTransaction_o, 0);
        if (c >= stopc + 4) break;
      end else if (bus.bus_dataValid_o) begin
        if (first < 0) begin
          first = c;
          chk("first_beat_latency", c, 2);
        end else chk("beat_spacing", c - last, GAP);
        last = c;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("rd_data", bus.bus_addrData_o, e);
        beats++;
        if (beats == stop_after) begin
          stopped = 1;
          stopc = c;
          if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk("reset_outputs_immediate", {bus.bus_addrData_o, bus.bus_dataValid_o, bus.bus_endTransaction_o,
                                            bus.bus_busy_o, bus.bus_error_o} == '0, 1);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
          end else begin
            bus.bus_endTransaction_i = 1'b1;
            @(posedge clk); #1;
            bus.bus_endTransaction_i = 1'b0;
          end
        end
      end else begin
        chk("rd_idle_data", bus.bus_addrData_o, 0);
        if (bus.bus_endTransaction_o) begin
          ends++;
          endc = c;
          break;
        end
      end
    end
    if (stopped) exp_q.delete();
    else begin
      chk("rd_end_count", ends, 1);
      chk("rd_end_after_last_beat", endc - last, 1);
      chk("rd_scoreboard_empty", exp_q.size(), 0);
    end
  endtask

  task automatic watch(input logic [31:0] addr, input logic [7:0] burst, input int exp_err);
    int errs = 0;
    logic [31:0] act = '0;
    begin_tx(addr, burst, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.bus_error_o) errs++;
      act |= bus.bus_addrData_o | 32'({bus.bus_dataValid_o, bus.bus_endTransaction_o, bus.bus_busy_o});
    end
    chk("watch_error_pulses", errs, exp_err);
    chk("watch_other_activity", act, 0);
  endtask

  initial begin
    idle_bus();
    #3;
    chk("reset_outputs", {bus.bus_addrData_o, bus.bus_dataValid_o, bus.bus_endTransaction_o,
                          bus.bus_busy_o, bus.bus_error_o} == '0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    write_words(32'h100, 8'd0, 4'hF, 32'hDEAD_BEEF, 0);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(32'h100, 8'd0, 0, 0);
    write_words(32'h200, 8'd0, 4'hF, 32'h1122_3344, 0);
    write_words(32'h200, 8'd0, 4'b0101, 32'hAABB_CCDD, 0);
    exp_q.push_back(32'h11BB_33DD);
    do_read(32'h200, 8'd0, 0, 0);
    write_words(32'h400, 8'd7, 4'hF, 32'h0, 1);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k));
    do_read(32'h400, 8'd7, 0, 0);
    watch(32'h6000_0000, 8'd0, 0);
    watch(32'h000F_FFFC, 8'd1, 1);
    exp_q.push_back(32'h0);
    do_read(32'h000F_FFFC, 8'd0, 0, 0);
    write_words(32'h800, 8'd15, 4'hF, 32'h100, 1);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
    do_read(32'h800, 8'd15, 3, 0);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(32'h100, 8'd0, 0, 0);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
    do_read(32'h800, 8'd15, 2, 1);
    exp_q.push_back(32'h11BB_33DD);
    do_read(32'h200, 8'd0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_mem_slave.md
Name: simple_mem_slave

Overview:
- Behavioural word-addressed RAM slave for the single-core SoC simulation bench; stands in for the 32 MB SDRAM.
- Decodes the shared multiplexed address/data bus, serves single and burst reads and writes, and drives its outputs on the ram* return inputs of the SoC.
- All outputs are 0 whenever the slave is not the addressed target, so its outputs can be OR-combined with other slaves.

Parameters:
- baseAddr, 32'h00000000, byte base address of the memory window.
- memSize, 1024*256, memory depth in 32-bit words; window = [baseAddr, baseAddr + 4*memSize).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- bus_addrData_i  in  32  address in the begin cycle, write data otherwise.
- bus_byteEnables_i  in  4  per-byte write enables; bit i enables byte lane i (bits 8i+7:8i).
- bus_burstSize_i  in  8  beats minus 1, sampled in the begin cycle.
- bus_readNWrite_i  in  1  1 = read, 0 = write, sampled in the begin cycle.
- bus_beginTransaction_i  in  1  start of transaction, one cycle.
- bus_endTransaction_i  in  1  master end or abort.
- bus_dataValid_i  in  1  write data valid.
- bus_addrData_o  out  32  read data; 0 when not valid.
- bus_endTransaction_o  out  1  end of read burst, one cycle.
- bus_dataValid_o  out  1  read data valid.
- bus_busy_o  out  1  wait request to master.
- bus_error_o  out  1  one-cycle error pulse.

Behaviour:
- Reset: async on rst_ni=0. State becomes IDLE and every output is 0. Memory contents are preserved. Memory initialises to 0 at time zero.
- Address decode (begin cycle):
  - Selected when baseAddr <= addr < baseAddr + 4*memSize.
  - Word index = (addr - baseAddr) >> 2; addr[1:0] are ignored.
  - An unselected begin leaves the slave in IDLE with all outputs 0.
- States: IDLE, READ, READ_END, WRITE, ERROR.
- Burst bound: if word index + burstSize >= memSize, go to ERROR. bus_error_o = 1 for exactly one cycle, then IDLE. No data is returned and nothing is written.
- IDLE -> READ when selected with readNWrite=1; IDLE -> WRITE when readNWrite=0.
- READ:
  - Beat k (k = 0..burstSize) places mem[index+k] on bus_addrData_o with bus_dataValid_o = 1.
  - Beat 0 appears 2 cycles after the begin cycle; following beats are on consecutive cycles.
  - After the last beat, go to READ_END.
- READ_END: bus_endTransaction_o = 1 for one cycle, then IDLE.
- WRITE:
  - Each cycle with bus_dataValid_i = 1 and bus_busy_o = 0 writes the enabled byte lanes of mem[index+k], then k increments.
  - Beats beyond burstSize+1 are ignored.
  - bus_endTransaction_i returns the slave to IDLE; the slave never drives endTransaction on writes.
- bus_endTransaction_i during READ or READ_END aborts immediately to IDLE; outputs are 0 from the next cycle.
- A bus_beginTransaction_i while not IDLE is ignored.
- bus_busy_o is 0 unless the optional feature is compiled in.

Optional Feature:
- Macro SIMPLE_MEM_SLAVE_WAITSTATE_EN.
- Defined:
  - During WRITE, bus_busy_o is asserted on the first cycle after the begin and after every accepted beat, i.e. one wait cycle per beat. Data presented while busy = 1 is not written; the master must hold it.
  - Reads insert one idle cycle (dataValid = 0) between consecutive beats.
- Undefined: bus_busy_o is tied to 0 and there are no gaps.

Test Plan:
- Reset: hold rst_ni=0 mid-read burst -> all outputs 0 immediately; after release, a read of a previously written word returns its value.
- Single write then read:
  - Write 0xDEADBEEF to 0x100 with byteEnables=4'hF, burstSize=0.
  - Read 0x100 -> one dataValid beat 0xDEADBEEF at begin+2, endTransaction at begin+3.
- Byte enables:
  - Write 0x11223344 to 0x200 with 4'hF, then 0xAABBCCDD with 4'b0101.
  - Read 0x200 -> 0x11BB33DD.
- Burst:
  - Write 8 beats (burstSize=7) of values 0..7 at 0x400.
  - Read with burstSize=7 -> 8 consecutive beats 0..7, then a single endTransaction.
- Out of range and bounds:
  - Begin at 0x60000000 -> no output activity.
  - Read of the last word (index memSize-1) with burstSize=1 -> bus_error_o pulse for one cycle, no dataValid.
- Abort: master endTransaction after beat 2 of a 16-beat read -> dataValid drops the next cycle, no slave endTransaction, and the slave accepts a new begin afterwards.
